instr_fetch: RTL

Instruction fetch unit: the producer side of the opcode interface that the main control decoder consumes. Holds the PC, fetches one 32-bit instruction at a time from instruction memory over a request/response handshake, and presents it (with `Op` = `Instr[31:26]`) to decode under a valid/ready handshake. On each accepted instruction it takes the decoder's `Jump`, `Branch` and ALU `Zero` to choose the next PC.

---
 rtl/instr_fetch.sv | 107 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, fetches one instruction at a time over a
// request/response memory handshake and presents it to decode under valid/ready.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [5:0]  Op,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] retired
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic [31:0] next_pc;

  // PCPlus4 is derived from the PC register, so it is stable for as long as the PC is.
  assign pc_plus4      = pc_q + 32'd4;
  assign jump_target   = {pc_plus4[31:28], instr_q[25:0], 2'b00};
  assign branch_target = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    if (Jump) begin
      next_pc = jump_target;
    end else if (Branch && Zero) begin
      next_pc = branch_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    imem_req  = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req = fetch_en;
        if (fetch_en && imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          retired_d = retired_q + 32'd1;
          pc_d      = next_pc;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      retired_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  assign imem_addr   = pc_q;
  assign Instr       = instr_q;
  assign Op          = instr_q[31:26];
  assign PCPlus4     = pc_plus4;
  assign instr_valid = (state_q == S_HOLD);
  assign retired     = retired_q;

endmodule
